// File: rtl/cond_issue_ctrl_pkg.sv
// Shared definitions for the issue-stage conditional-execution controller:
// ARM condition codes and the bit positions of N, Z, C, V inside an NZCV nibble.
package cond_issue_ctrl_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int MAX_PEND_DEF = 3;
    localparam int PEND_W_DEF   = $clog2(MAX_PEND_DEF + 1);

endpackage

// File: rtl/cond_issue_ctrl_if.sv
// Bundle of the decode-side handshake, execute-side verdict, ALU flag writeback
// and status signals around the conditional-issue controller.
interface cond_issue_ctrl_if
    import cond_issue_ctrl_pkg::*;
#(
    parameter int PEND_W = PEND_W_DEF
);
    logic              inValid;
    logic              inReady;
    logic [3:0]        inCond;
    logic              inSetFlags;
    logic              outValid;
    logic              outReady;
    logic              outExec;
    logic              outSetFlags;
    logic [3:0]        outCond;
    logic              flagWrEn;
    logic [3:0]        flagWrData;
    logic [3:0]        flags;
    logic [PEND_W-1:0] pendCount;
    logic              flagErr;

    modport master (
        output inValid, inCond, inSetFlags, outReady, flagWrEn, flagWrData,
        input  inReady, outValid, outExec, outSetFlags, outCond, flags, pendCount, flagErr
    );

    modport slave (
        input  inValid, inCond, inSetFlags, outReady, flagWrEn, flagWrData,
        output inReady, outValid, outExec, outSetFlags, outCond, flags, pendCount, flagErr
    );

endinterface

// File: rtl/cond_issue_ctrl_cond_eval.sv
// Combinational ARM condition evaluator: decides whether a condition field is
// satisfied by an NZCV nibble. AL always passes, NV never does.
module cond_issue_ctrl_cond_eval
    import cond_issue_ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       met_o
);

    logic n, z, c, v;

    assign n = nzcv_i[FLAG_N];
    assign z = nzcv_i[FLAG_Z];
    assign c = nzcv_i[FLAG_C];
    assign v = nzcv_i[FLAG_V];

    // Decode the condition field against the flags
    always_comb begin
        met_o = 1'b0;
        case (cond_i)
            COND_EQ: met_o = z;
            COND_NE: met_o = ~z;
            COND_CS: met_o = c;
            COND_CC: met_o = ~c;
            COND_MI: met_o = n;
            COND_PL: met_o = ~n;
            COND_VS: met_o = v;
            COND_VC: met_o = ~v;
            COND_HI: met_o = c & ~z;
            COND_LS: met_o = ~c | z;
            COND_GE: met_o = (n == v);
            COND_LT: met_o = (n != v);
            COND_GT: met_o = ~z & (n == v);
            COND_LE: met_o = z | (n != v);
            COND_AL: met_o = 1'b1;
            default: met_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_issue_ctrl.sv
// Issue-stage conditional-execution controller. Holds architectural NZCV,
// counts in-flight flag setters, stalls conditional instructions until their
// flags resolve (with same-cycle writeback bypass) and registers the verdict.
module cond_issue_ctrl
    import cond_issue_ctrl_pkg::*;
#(
    parameter int MAX_PEND = MAX_PEND_DEF
)(
    input  logic             clk_i,
    input  logic             reset_i,
    cond_issue_ctrl_if.slave bus
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);

    logic              outValid_q, outValid_d;
    logic              outExec_q, outExec_d;
    logic              outSetFlags_q, outSetFlags_d;
    logic [3:0]        outCond_q, outCond_d;
    logic [3:0]        flags_q, flags_d;
    logic [PEND_W-1:0] pend_q, pend_d;
    logic              flagErr_q, flagErr_d;

    logic              validWrite;
    logic [3:0]        effFlags;
    logic [PEND_W-1:0] effPend;
    logic              needFlags;
    logic              stall;
    logic              inReady;
    logic              accept;
    logic              met;
    logic              incPend;

    // A writeback only counts when a setter is actually outstanding
    assign validWrite = bus.flagWrEn & (pend_q != '0);
    assign effFlags   = validWrite ? bus.flagWrData : flags_q;
    assign effPend    = pend_q - PEND_W'(validWrite);
    assign needFlags  = (bus.inCond != COND_AL) && (bus.inCond != COND_NV);
    assign stall      = (needFlags & (effPend != '0)) |
                        (bus.inSetFlags & (effPend == PEND_W'(MAX_PEND)));
    assign inReady    = ~reset_i & (~outValid_q | bus.outReady) & ~stall;
    assign accept     = bus.inValid & inReady;
    assign incPend    = accept & bus.inSetFlags & met;

    cond_issue_ctrl_cond_eval u_cond_eval (
        .cond_i (bus.inCond),
        .nzcv_i (effFlags),
        .met_o  (met)
    );

    // Next-state for the verdict register, pending counter, flags and error flag
    always_comb begin
        outValid_d    = outValid_q;
        outExec_d     = outExec_q;
        outSetFlags_d = outSetFlags_q;
        outCond_d     = outCond_q;
        flags_d       = flags_q;
        pend_d        = pend_q;
        flagErr_d     = flagErr_q;

        if (accept) begin
            outValid_d    = 1'b1;
            outExec_d     = met;
            outSetFlags_d = bus.inSetFlags & met;
            outCond_d     = bus.inCond;
        end else if (outValid_q & bus.outReady) begin
            outValid_d = 1'b0;
        end

        if (incPend & ~validWrite) begin
            pend_d = pend_q + PEND_W'(1);
        end else if (~incPend & validWrite) begin
            pend_d = pend_q - PEND_W'(1);
        end

        if (validWrite) begin
            flags_d = bus.flagWrData;
        end

        if (bus.flagWrEn & (pend_q == '0)) begin
            flagErr_d = 1'b1;
        end
    end

    // State registers with synchronous reset discarding any in-flight work
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outValid_q    <= 1'b0;
            outExec_q     <= 1'b0;
            outSetFlags_q <= 1'b0;
            outCond_q     <= 4'b0000;
            flags_q       <= 4'b0000;
            pend_q        <= '0;
            flagErr_q     <= 1'b0;
        end else begin
            outValid_q    <= outValid_d;
            outExec_q     <= outExec_d;
            outSetFlags_q <= outSetFlags_d;
            outCond_q     <= outCond_d;
            flags_q       <= flags_d;
            pend_q        <= pend_d;
            flagErr_q     <= flagErr_d;
        end
    end

    assign bus.inReady     = inReady;
    assign bus.outValid    = outValid_q;
    assign bus.outExec     = outExec_q;
    assign bus.outSetFlags = outSetFlags_q;
    assign bus.outCond     = outCond_q;
    assign bus.flags       = flags_q;
    assign bus.pendCount   = pend_q;
    assign bus.flagErr     = flagErr_q;

endmodule

// File: tb/tb_cond_issue_ctrl.sv
// Directed testbench for cond_issue_ctrl: issues hand-built instruction
// sequences and compares outputs against hand-computed expectations.
module tb_cond_issue_ctrl;
    import cond_issue_ctrl_pkg::*;

    logic clk;
    logic reset;
    int   vectorCount;
    int   missCount;

    cond_issue_ctrl_if bus ();

    cond_issue_ctrl dut (
        .clk_i   (clk),
        .reset_i (reset),
        .bus     (bus)
    );

    // Free-running clock, 10 time units per period
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectorCount++;
        if (observed !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input logic [3:0] cond,
                                 input logic setFlags);
        bus.inValid    = valid;
        bus.inCond     = cond;
        bus.inSetFlags = setFlags;
        #1;
    endtask

    task automatic flagWrite(input logic en, input logic [3:0] data);
        bus.flagWrEn   = en;
        bus.flagWrData = data;
        #1;
    endtask

    // Directed scenarios: reset, bypass resolve, backpressure, saturation,
    // failed/never conditions, error flag and reset mid-stall
    initial begin
        vectorCount    = 0;
        missCount      = 0;
        reset          = 1'b1;
        bus.inValid    = 1'b0;
        bus.inCond     = 4'b0000;
        bus.inSetFlags = 1'b0;
        bus.outReady   = 1'b1;
        bus.flagWrEn   = 1'b0;
        bus.flagWrData = 4'b0000;
        tick();
        tick();
        checkOutput("rst_outValid", bus.outValid, 0);
        checkOutput("rst_outExec", bus.outExec, 0);
        checkOutput("rst_outSetFlags", bus.outSetFlags, 0);
        checkOutput("rst_outCond", bus.outCond, 0);
        checkOutput("rst_flags", bus.flags, 0);
        checkOutput("rst_pend", bus.pendCount, 0);
        checkOutput("rst_flagErr", bus.flagErr, 0);
        applyStimulus(1'b1, COND_AL, 1'b0);
        checkOutput("rst_inReadyLow", bus.inReady, 0);
        applyStimulus(1'b0, COND_AL, 1'b0);
        reset = 1'b0;
        #1;

        // 1: plain AL instruction executes after one cycle
        applyStimulus(1'b1, COND_AL, 1'b0);
        checkOutput("t1_inReady", bus.inReady, 1);
        tick();
        applyStimulus(1'b0, COND_AL, 1'b0);
        checkOutput("t1_outValid", bus.outValid, 1);
        checkOutput("t1_outExec", bus.outExec, 1);
        checkOutput("t1_outCond", bus.outCond, 4'hE);
        checkOutput("t1_outSetFlags", bus.outSetFlags, 0);
        checkOutput("t1_flags", bus.flags, 0);
        checkOutput("t1_pend", bus.pendCount, 0);
        tick();
        checkOutput("t1_drained", bus.outValid, 0);

        // 2: CMP then BEQ stalls, resolves with bypassed flags on writeback
        applyStimulus(1'b1, COND_AL, 1'b1);
        tick();
        checkOutput("t2_cmpPend", bus.pendCount, 1);
        checkOutput("t2_cmpSetFlags", bus.outSetFlags, 1);
        applyStimulus(1'b1, COND_EQ, 1'b0);
        checkOutput("t2_beqStall", bus.inReady, 0);
        tick();
        checkOutput("t2_stallPend", bus.pendCount, 1);
        checkOutput("t2_stallNoValid", bus.outValid, 0);
        flagWrite(1'b1, 4'b0100);
        checkOutput("t2_bypassReady", bus.inReady, 1);
        tick();
        flagWrite(1'b0, 4'b0000);
        applyStimulus(1'b0, COND_AL, 1'b0);
        checkOutput("t2_beqValid", bus.outValid, 1);
        checkOutput("t2_beqExec", bus.outExec, 1);
        checkOutput("t2_beqCond", bus.outCond, 0);
        checkOutput("t2_pend", bus.pendCount, 0);
        checkOutput("t2_flags", bus.flags, 4'b0100);

        // 3: backpressure holds the verdict stable
        applyStimulus(1'b1, COND_EQ, 1'b0);
        tick();
        bus.outReady = 1'b0;
        applyStimulus(1'b1, COND_NE, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("t3_inReady", bus.inReady, 0);
            tick();
            checkOutput("t3_holdValid", bus.outValid, 1);
            checkOutput("t3_holdExec", bus.outExec, 1);
            checkOutput("t3_holdCond", bus.outCond, 0);
        end
        bus.outReady = 1'b1;
        #1;
        checkOutput("t3_releaseReady", bus.inReady, 1);
        tick();
        applyStimulus(1'b0, COND_AL, 1'b0);
        checkOutput("t3_neCond", bus.outCond, 4'b0001);
        checkOutput("t3_neExec", bus.outExec, 0);
        tick();
        checkOutput("t3_drained", bus.outValid, 0);

        // 4: pending counter saturates at three setters
        applyStimulus(1'b1, COND_AL, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            tick();
            checkOutput("t4_pendUp", bus.pendCount, i);
        end
        checkOutput("t4_satStall", bus.inReady, 0);
        tick();
        checkOutput("t4_satHold", bus.pendCount, 3);
        checkOutput("t4_satNoValid", bus.outValid, 0);
        flagWrite(1'b1, 4'b0000);
        checkOutput("t4_bypassReady", bus.inReady, 1);
        tick();
        applyStimulus(1'b0, COND_AL, 1'b0);
        checkOutput("t4_incDecPend", bus.pendCount, 3);
        checkOutput("t4_acceptValid", bus.outValid, 1);
        tick();
        tick();
        flagWrite(1'b1, 4'b0100);
        tick();
        flagWrite(1'b0, 4'b0000);
        checkOutput("t4_drainPend", bus.pendCount, 0);
        checkOutput("t4_drainFlags", bus.flags, 4'b0100);

        // 5: failed setter is not counted; NV squashes without stalling
        applyStimulus(1'b1, COND_NE, 1'b1);
        checkOutput("t5_neReady", bus.inReady, 1);
        tick();
        checkOutput("t5_neValid", bus.outValid, 1);
        checkOutput("t5_neExec", bus.outExec, 0);
        checkOutput("t5_neSetFlags", bus.outSetFlags, 0);
        checkOutput("t5_nePend", bus.pendCount, 0);
        applyStimulus(1'b1, COND_AL, 1'b1);
        tick();
        checkOutput("t5_setterPend", bus.pendCount, 1);
        applyStimulus(1'b1, COND_NV, 1'b0);
        checkOutput("t5_nvReady", bus.inReady, 1);
        tick();
        applyStimulus(1'b0, COND_AL, 1'b0);
        checkOutput("t5_nvExec", bus.outExec, 0);
        checkOutput("t5_nvCond", bus.outCond, 4'hF);
        checkOutput("t5_nvPend", bus.pendCount, 1);

        // 6: stray writeback sets sticky error; reset during stall clears all
        flagWrite(1'b1, 4'b0100);
        tick();
        checkOutput("t6_clearPend", bus.pendCount, 0);
        flagWrite(1'b1, 4'b1111);
        tick();
        flagWrite(1'b0, 4'b0000);
        checkOutput("t6_flagErr", bus.flagErr, 1);
        checkOutput("t6_flagsKept", bus.flags, 4'b0100);
        checkOutput("t6_pendZero", bus.pendCount, 0);
        tick();
        checkOutput("t6_flagErrSticky", bus.flagErr, 1);
        applyStimulus(1'b1, COND_AL, 1'b1);
        tick();
        bus.outReady = 1'b0;
        applyStimulus(1'b1, COND_EQ, 1'b0);
        checkOutput("t6_stalled", bus.inReady, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.outReady = 1'b1;
        applyStimulus(1'b0, COND_AL, 1'b0);
        checkOutput("t6_rstFlags", bus.flags, 0);
        checkOutput("t6_rstPend", bus.pendCount, 0);
        checkOutput("t6_rstFlagErr", bus.flagErr, 0);
        checkOutput("t6_rstValid", bus.outValid, 0);
        checkOutput("t6_rstExec", bus.outExec, 0);
        checkOutput("t6_rstCond", bus.outCond, 0);
        tick();
        checkOutput("t6_noVerdict", bus.outValid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
